// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin write-back arbiter for the 32x32 register file
//
// Purpose: grants one of NREQ write-back requesters per cycle (round robin),
// registers the winning write into rf_we/rf_wn/rf_d, and keeps a pending-write
// scoreboard (busy) for the decode stage.
//
// Ports:
//   clk          clock, rising edge
//   clrn         synchronous active-high reset
//   req_valid    per-requester write pending
//   req_wn       per-requester destination, slice [5i+4:5i]
//   req_d        per-requester write data, slice [32i+31:32i]
//   req_ready    one-hot-or-zero grant
//   claim_valid  decode claims claim_wn as an outstanding destination
//   claim_wn     claimed destination
//   rf_we        register-file write enable (registered)
//   rf_wn        register-file write address (registered)
//   rf_d         register-file write data (registered)
//   busy         busy[r]=1 while register r has an outstanding write; busy[0]=0

module regfile_wb_arbiter #(
  parameter int NREQ = 3
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [5*NREQ-1:0]  req_wn,
  input  logic [32*NREQ-1:0] req_d,
  output logic [NREQ-1:0]    req_ready,
  input  logic               claim_valid,
  input  logic [4:0]         claim_wn,
  output logic               rf_we,
  output logic [4:0]         rf_wn,
  output logic [31:0]        rf_d,
  output logic [31:0]        busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   nxt_ptr;
  logic [NREQ-1:0] grant;
  logic            gnt_any;
  logic [4:0]      sel_wn;
  logic [31:0]     sel_d;
  logic [31:1]     busy_q;
  int              scan_idx;

  // Scan from rr_ptr, wrapping modulo NREQ; first valid requester wins.
  always_comb begin
    grant    = '0;
    gnt_any  = 1'b0;
    sel_wn   = '0;
    sel_d    = '0;
    nxt_ptr  = rr_ptr;
    scan_idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
      if (!gnt_any && req_valid[scan_idx]) begin
        gnt_any         = 1'b1;
        grant[scan_idx] = 1'b1;
        sel_wn          = req_wn[scan_idx*5 +: 5];
        sel_d           = req_d[scan_idx*32 +: 32];
        nxt_ptr         = (scan_idx == NREQ - 1) ? '0 : PW'(scan_idx + 1);
      end
    end
  end

  // Grant is suppressed during reset so no handshake is seen as completed.
  assign req_ready = clrn ? '0 : grant;
  assign busy      = {busy_q, 1'b0};

  always_ff @(posedge clk) begin
    if (clrn) begin
      rr_ptr <= '0;
      rf_we  <= 1'b0;
      rf_wn  <= '0;
      rf_d   <= '0;
      busy_q <= '0;
    end else begin
      if (gnt_any) begin
        // Register 0 writes retire through the handshake but never reach the file.
        rf_we  <= (sel_wn != 5'd0);
        rf_wn  <= sel_wn;
        rf_d   <= sel_d;
        rr_ptr <= nxt_ptr;
      end else begin
        rf_we <= 1'b0;
      end
      // Clear on the edge that commits the write; a same-cycle claim wins.
      for (int r = 1; r < 32; r++) begin
        busy_q[r] <= (claim_valid && (claim_wn == 5'(r))) ||
                     (busy_q[r] && !(rf_we && (rf_wn == 5'(r))));
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench for regfile_wb_arbiter

module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        clrn;
  logic [2:0]  req_valid;
  logic [14:0] req_wn;
  logic [95:0] req_d;
  logic [2:0]  req_ready;
  logic        claim_valid;
  logic [4:0]  claim_wn;
  logic        rf_we;
  logic [4:0]  rf_wn;
  logic [31:0] rf_d;
  logic [31:0] busy;

  regfile_wb_arbiter #(.NREQ(3)) dut (
    .clk(clk), .clrn(clrn),
    .req_valid(req_valid), .req_wn(req_wn), .req_d(req_d), .req_ready(req_ready),
    .claim_valid(claim_valid), .claim_wn(claim_wn),
    .rf_we(rf_we), .rf_wn(rf_wn), .rf_d(rf_d), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  wn;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fails  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] wn, input logic [31:0] d);
    req_valid[i]       = 1'b1;
    req_wn[i*5 +: 5]   = wn;
    req_d[i*32 +: 32]  = d;
  endtask

  // Checks the grant against the bench's expected winner and queues that
  // requester's write (writes to r0 never produce rf_we, so nothing is queued).
  task automatic expect_grant(input string name, input int i);
    wr_t e;
    check(name, 64'(req_ready), 64'(3'b001 << i));
    e.wn = req_wn[i*5 +: 5];
    e.d  = req_d[i*32 +: 32];
    if (e.wn != 5'd0) exp_q.push_back(e);
  endtask

  // Monitor: every cycle the DUT presents a write, it must match the queue head.
  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge clk);
      if (rf_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL unexpected_write: got wn=%0d d=%h, expected no write", rf_wn, rf_d);
        end else begin
          e = exp_q.pop_front();
          check("rf_wn", 64'(rf_wn), 64'(e.wn));
          check("rf_d", 64'(rf_d), 64'(e.d));
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clrn = 1'b1; req_valid = '0; req_wn = '0; req_d = '0;
    claim_valid = 1'b0; claim_wn = '0;

    // Reset with inputs toggling
    for (int c = 0; c < 2; c++) begin
      req_valid   = 3'($urandom);
      req_wn      = 15'($urandom);
      req_d       = {$urandom, $urandom, $urandom};
      claim_valid = 1'b1;
      claim_wn    = 5'(c + 3);
      @(negedge clk);
      check("rst_ready", 64'(req_ready), 64'd0);
      check("rst_we", 64'(rf_we), 64'd0);
      check("rst_wn", 64'(rf_wn), 64'd0);
      check("rst_d", 64'(rf_d), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      step();
    end
    clrn = 1'b0; req_valid = '0; claim_valid = 1'b0;

    // Round robin, all valid; each winner re-presents a fresh payload
    for (int i = 0; i < 3; i++) set_req(i, 5'(10 + i), 32'hA000_0000 + 32'(i));
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      expect_grant($sformatf("rr_grant%0d", c), c % 3);
      step();
      if (c + 3 < 6) set_req(c % 3, 5'(13 + c), 32'hA000_0003 + 32'(c));
      else req_valid[c % 3] = 1'b0;
    end

    // Single requester (rr_ptr back at 0)
    set_req(1, 5'd5, 32'hDEAD_BEEF);
    @(negedge clk);
    expect_grant("single_grant", 1);
    step();
    req_valid = '0;
    @(negedge clk);
    check("single_we", 64'(rf_we), 64'd1);
    step();
    @(negedge clk);
    check("single_we_drop", 64'(rf_we), 64'd0);
    step();

    // Register 0 write (rr_ptr now 2)
    set_req(2, 5'd0, 32'h1234_5678);
    @(negedge clk);
    expect_grant("r0_grant", 2);
    step();
    req_valid = '0;
    @(negedge clk);
    check("r0_we", 64'(rf_we), 64'd0);
    step();
    set_req(0, 5'd9,  32'h9999_0000);
    set_req(1, 5'd10, 32'h9999_0001);
    set_req(2, 5'd11, 32'h9999_0002);
    @(negedge clk);
    expect_grant("r0_ptr_wrap", 0);
    step();
    req_valid = '0;

    // Scoreboard: claim r7, write r7 two cycles later (rr_ptr now 1)
    claim_valid = 1'b1; claim_wn = 5'd7;
    step();
    claim_valid = 1'b0;
    @(negedge clk);
    check("sb_busy_c1", 64'(busy[7]), 64'd1);
    step();
    set_req(0, 5'd7, 32'h7777_0001);
    @(negedge clk);
    check("sb_busy_c2", 64'(busy[7]), 64'd1);
    expect_grant("sb_grant", 0);
    step();
    req_valid = '0;
    @(negedge clk);
    check("sb_busy_c3", 64'(busy[7]), 64'd1);
    check("sb_we_c3", 64'(rf_we), 64'd1);
    step();
    @(negedge clk);
    check("sb_busy_c4", 64'(busy[7]), 64'd0);
    step();

    // Scoreboard: claim coinciding with the committing write keeps busy set
    claim_valid = 1'b1; claim_wn = 5'd7;
    step();
    claim_valid = 1'b0;
    set_req(0, 5'd7, 32'h7777_0002);
    @(negedge clk);
    check("sb2_busy", 64'(busy[7]), 64'd1);
    expect_grant("sb2_grant", 0);
    step();
    req_valid = '0;
    claim_valid = 1'b1; claim_wn = 5'd7;
    @(negedge clk);
    check("sb2_we", 64'(rf_we), 64'd1);
    step();
    claim_valid = 1'b1; claim_wn = 5'd0;
    @(negedge clk);
    check("sb2_busy_kept", 64'(busy[7]), 64'd1);
    step();
    claim_valid = 1'b0;
    @(negedge clk);
    check("sb_r0_ignored", 64'(busy), 64'h80);
    step();

    // Reset mid-stream (rr_ptr now 1)
    set_req(1, 5'd20, 32'h2020_0000);
    @(negedge clk);
    expect_grant("mid_pre1", 1);
    step();
    set_req(0, 5'd21, 32'h2121_0000);
    set_req(1, 5'd22, 32'h2222_0000);
    @(negedge clk);
    expect_grant("mid_pre0", 0);
    step();
    set_req(0, 5'd23, 32'h2323_0000);
    clrn = 1'b1;
    @(negedge clk);
    check("mid_rst_ready1", 64'(req_ready), 64'd0);
    step();
    @(negedge clk);
    check("mid_rst_ready2", 64'(req_ready), 64'd0);
    check("mid_rst_we", 64'(rf_we), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    step();
    clrn = 1'b0;
    @(negedge clk);
    expect_grant("mid_restart0", 0);
    step();
    req_valid[0] = 1'b0;
    @(negedge clk);
    expect_grant("mid_restart1", 1);
    step();
    req_valid = '0;

    for (int c = 0; c < 3; c++) step();
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
